vcve2_vec_offload_rx: RTL and testbench

Coprocessor-side receiver for vector instructions (opcodes LOAD_V 0x07, STORE_V 0x27, OP_V 0x57) offloaded by the vcve2 core. It sits between the core's offload port and the vector execution unit. Accepted instructions are classified, and configuration instructions (vsetvli/vsetivli/vsetvl) execute locally against the vl/vtype state. Vector operations are buffered in an in-order FIFO tagged with a vl/SEW snapshot, and exactly one in-order response is returned to the core per accepted instruction.

---
 rtl/vcve2_vec_offload_rx.sv | 251 +++++++++++++++++++++++++
 tb/tb_vcve2_vec_offload_rx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcve2_vec_offload_rx.sv
// vcve2_vec_offload_rx
//
// Coprocessor-side receiver for vector instructions offloaded by the vcve2 core.
// Each accepted instruction is classified as illegal, configuration
// (vsetvli / vsetivli / vsetvl) or vector operation.
// - Configuration instructions update the local vl/vtype state.
// - Vector operations are queued in an in-order FIFO, together with a
//   snapshot of vl and SEW taken when they are accepted.
// - The core gets exactly one in-order response per accepted instruction.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 2)
//   VLEN   vector register length in bits (power of two, 64..1024)
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   flush_i                    synchronous flush of FIFO and pending response
//   issue_*                    offload issue handshake, instruction and operands
//   resp_*                     offload response (rd data, write enable, illegal)
//   vinstr_*                   FIFO head towards the vector execution unit
//   vl_o, vtype_o              current architectural vl / vtype

module vcve2_vec_offload_rx #(
    parameter int DEPTH = 4,
    parameter int VLEN  = 128
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        issue_valid_i,
    output logic        issue_ready_o,
    input  logic [31:0] issue_instr_i,
    input  logic [31:0] issue_rs1_i,
    input  logic [31:0] issue_rs2_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_we_o,
    output logic        resp_illegal_o,
    output logic        vinstr_valid_o,
    input  logic        vinstr_ready_i,
    output logic [31:0] vinstr_o,
    output logic [31:0] vinstr_rs1_o,
    output logic [31:0] vinstr_rs2_o,
    output logic [1:0]  vinstr_kind_o,
    output logic [31:0] vinstr_vl_o,
    output logic [2:0]  vinstr_vsew_o,
    output logic [31:0] vl_o,
    output logic [31:0] vtype_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0]  OPC_LOAD  = 7'h07;
    localparam logic [6:0]  OPC_STORE = 7'h27;
    localparam logic [6:0]  OPC_OPV   = 7'h57;
    localparam logic [31:0] VTYPE_ILL = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  kind;
        logic [31:0] vl;
        logic [2:0]  vsew;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           push_entry;
    entry_t           head;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_we_q, resp_we_d;
    logic             resp_illegal_q, resp_illegal_d;
    logic [31:0]      vl_q, vl_d;
    logic [31:0]      vtype_q, vtype_d;

    logic             fifo_full, fifo_empty;
    logic             accept, push, pop;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [4:0]       rs1_idx, rd_idx;
    logic             is_vec_opc, is_cfg;
    logic             cfg_legal, cfg_vill;
    logic [31:0]      cfg_vtype_raw, cfg_avl, cfg_vlmax, cfg_vl, cfg_vtype;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // Ready depends only on registered state, resp_ready_i and flush_i, so a
    // full FIFO stalls issue even when the head is popped in the same cycle.
    assign issue_ready_o = !fifo_full && (!resp_valid_q || resp_ready_i) && !flush_i;
    assign accept        = issue_valid_i && issue_ready_o;
    assign pop           = !fifo_empty && vinstr_ready_i;

    assign opcode     = issue_instr_i[6:0];
    assign funct3     = issue_instr_i[14:12];
    assign rs1_idx    = issue_instr_i[19:15];
    assign rd_idx     = issue_instr_i[11:7];
    assign is_vec_opc = (opcode == OPC_LOAD) || (opcode == OPC_STORE) || (opcode == OPC_OPV);
    assign is_cfg     = (opcode == OPC_OPV) && (funct3 == 3'b111);

    // Configuration decode: pick the new vtype and AVL, then clamp to VLMAX.
    // vlmul[2] set means fractional LMUL, which is treated as vill, so only
    // vlmul[1:0] feeds the VLMAX shift.
    always_comb begin
        cfg_legal     = 1'b1;
        cfg_vtype_raw = '0;
        if (!issue_instr_i[31]) begin
            cfg_vtype_raw = {21'b0, issue_instr_i[30:20]};
        end else if (issue_instr_i[31:30] == 2'b11) begin
            cfg_vtype_raw = {22'b0, issue_instr_i[29:20]};
        end else if (issue_instr_i[31:25] == 7'b1000000) begin
            cfg_vtype_raw = issue_rs2_i;
        end else begin
            cfg_legal = 1'b0;
        end

        if (issue_instr_i[31:30] == 2'b11) begin
            cfg_avl = {27'b0, rs1_idx};
        end else if (rs1_idx != 5'd0) begin
            cfg_avl = issue_rs1_i;
        end else if (rd_idx != 5'd0) begin
            cfg_avl = 32'hFFFF_FFFF;
        end else begin
            cfg_avl = vl_q;
        end

        cfg_vill  = (cfg_vtype_raw[5:3] >= 3'd3) || cfg_vtype_raw[2] || (|cfg_vtype_raw[31:8]);
        cfg_vlmax = (32'(VLEN) << cfg_vtype_raw[1:0]) >> ({1'b0, cfg_vtype_raw[5:3]} + 4'd3);
        cfg_vl    = cfg_vill ? 32'd0 : ((cfg_avl < cfg_vlmax) ? cfg_avl : cfg_vlmax);
        cfg_vtype = cfg_vill ? VTYPE_ILL : cfg_vtype_raw;
    end

    // Response, architectural state and FIFO bookkeeping.
    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        resp_valid_d   = resp_valid_q;
        resp_rdata_d   = resp_rdata_q;
        resp_we_d      = resp_we_q;
        resp_illegal_d = resp_illegal_q;
        vl_d           = vl_q;
        vtype_d        = vtype_q;
        push           = 1'b0;

        push_entry.instr = issue_instr_i;
        push_entry.rs1   = issue_rs1_i;
        push_entry.rs2   = issue_rs2_i;
        push_entry.kind  = (opcode == OPC_LOAD) ? 2'b00 : ((opcode == OPC_STORE) ? 2'b01 : 2'b10);
        push_entry.vl    = vl_q;
        push_entry.vsew  = vtype_q[5:3];

        if (flush_i) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            resp_valid_d = 1'b0;
        end else begin
            if (resp_valid_q && resp_ready_i) begin
                resp_valid_d = 1'b0;
            end
            if (accept) begin
                resp_valid_d   = 1'b1;
                resp_rdata_d   = '0;
                resp_we_d      = 1'b0;
                resp_illegal_d = 1'b0;
                if (!is_vec_opc || (is_cfg && !cfg_legal)) begin
                    resp_illegal_d = 1'b1;
                end else if (is_cfg) begin
                    resp_rdata_d = cfg_vl;
                    resp_we_d    = (rd_idx != 5'd0);
                    vl_d         = cfg_vl;
                    vtype_d      = cfg_vtype;
                end else if (vtype_q[31]) begin
                    resp_illegal_d = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_we_q      <= 1'b0;
            resp_illegal_q <= 1'b0;
            vl_q           <= '0;
            vtype_q        <= VTYPE_ILL;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_we_q      <= resp_we_d;
            resp_illegal_q <= resp_illegal_d;
            vl_q           <= vl_d;
            vtype_q        <= vtype_d;
        end
    end

    // Storage needs no reset: the head outputs are gated by the count, so
    // stale entries are never visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign vinstr_valid_o = !fifo_empty;
    assign vinstr_o       = vinstr_valid_o ? head.instr : '0;
    assign vinstr_rs1_o   = vinstr_valid_o ? head.rs1   : '0;
    assign vinstr_rs2_o   = vinstr_valid_o ? head.rs2   : '0;
    assign vinstr_kind_o  = vinstr_valid_o ? head.kind  : '0;
    assign vinstr_vl_o    = vinstr_valid_o ? head.vl    : '0;
    assign vinstr_vsew_o  = vinstr_valid_o ? head.vsew  : '0;

    assign resp_valid_o   = resp_valid_q;
    assign resp_rdata_o   = resp_rdata_q;
    assign resp_we_o      = resp_we_q;
    assign resp_illegal_o = resp_illegal_q;
    assign vl_o           = vl_q;
    assign vtype_o        = vtype_q;

endmodule

// File: tb/tb_vcve2_vec_offload_rx.sv
// Testbench for vcve2_vec_offload_rx (DEPTH = 4, VLEN = 128).
// A table of directed vectors is applied one clock each; the hand-written
// sequences at the end cover flush and asynchronous reset with a busy FIFO.

module tb_vcve2_vec_offload_rx;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [31:0] issue_rs1_i;
    logic [31:0] issue_rs2_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_we_o;
    logic        resp_illegal_o;
    logic        vinstr_valid_o;
    logic        vinstr_ready_i;
    logic [31:0] vinstr_o;
    logic [31:0] vinstr_rs1_o;
    logic [31:0] vinstr_rs2_o;
    logic [1:0]  vinstr_kind_o;
    logic [31:0] vinstr_vl_o;
    logic [2:0]  vinstr_vsew_o;
    logic [31:0] vl_o;
    logic [31:0] vtype_o;

    int checks = 0;
    int passes = 0;

    vcve2_vec_offload_rx #(.DEPTH(4), .VLEN(128)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_instr_i  (issue_instr_i),
        .issue_rs1_i    (issue_rs1_i),
        .issue_rs2_i    (issue_rs2_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_rdata_o   (resp_rdata_o),
        .resp_we_o      (resp_we_o),
        .resp_illegal_o (resp_illegal_o),
        .vinstr_valid_o (vinstr_valid_o),
        .vinstr_ready_i (vinstr_ready_i),
        .vinstr_o       (vinstr_o),
        .vinstr_rs1_o   (vinstr_rs1_o),
        .vinstr_rs2_o   (vinstr_rs2_o),
        .vinstr_kind_o  (vinstr_kind_o),
        .vinstr_vl_o    (vinstr_vl_o),
        .vinstr_vsew_o  (vinstr_vsew_o),
        .vl_o           (vl_o),
        .vtype_o        (vtype_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        int          valid;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          rr;
        int          vr;
        int          fl;
        logic [31:0] e_ready;
        logic [31:0] e_rvalid;
        logic [31:0] e_rdata;
        logic [31:0] e_we;
        logic [31:0] e_ill;
        logic [31:0] e_vvalid;
        logic [31:0] e_vinstr;
        logic [31:0] e_kind;
        logic [31:0] e_vvl;
        logic [31:0] e_vsew;
        logic [31:0] e_vl;
        logic [31:0] e_vtype;
    } vec_t;

    vec_t vecs[$];

    // Instruction encoders
    function automatic logic [31:0] vsetvli(input int rd, input int rs1, input int vt);
        logic [31:0] r = rd, s = rs1, t = vt;
        return {1'b0, t[10:0], s[4:0], 3'b111, r[4:0], 7'h57};
    endfunction

    function automatic logic [31:0] vsetivli(input int rd, input int uimm, input int vt);
        logic [31:0] r = rd, u = uimm, t = vt;
        return {2'b11, t[9:0], u[4:0], 3'b111, r[4:0], 7'h57};
    endfunction

    function automatic logic [31:0] vsetvl(input int rd, input int rs1, input int rs2);
        logic [31:0] r = rd, s = rs1, t = rs2;
        return {7'b1000000, t[4:0], s[4:0], 3'b111, r[4:0], 7'h57};
    endfunction

    function automatic logic [31:0] opv(input int vd);
        logic [31:0] d = vd;
        return {7'b0000001, 5'd2, 5'd1, 3'b000, d[4:0], 7'h57};
    endfunction

    function automatic logic [31:0] ld(input int vd);
        logic [31:0] d = vd;
        return {12'h000, 5'd10, 3'b110, d[4:0], 7'h07};
    endfunction

    function automatic logic [31:0] st(input int vd);
        logic [31:0] d = vd;
        return {12'h000, 5'd10, 3'b110, d[4:0], 7'h27};
    endfunction

    function automatic vec_t mk(input string n, input int v, input logic [31:0] ins, input logic [31:0] a,
                                input logic [31:0] b, input int rr, input int vr, input int fl,
                                input logic [31:0] er, input logic [31:0] erv, input logic [31:0] erd,
                                input logic [31:0] ewe, input logic [31:0] eill, input logic [31:0] evv,
                                input logic [31:0] evi, input logic [31:0] ek, input logic [31:0] evl,
                                input logic [31:0] evs, input logic [31:0] el, input logic [31:0] etp);
        vec_t x;
        x.name = n; x.valid = v; x.instr = ins; x.rs1 = a; x.rs2 = b; x.rr = rr; x.vr = vr; x.fl = fl;
        x.e_ready = er; x.e_rvalid = erv; x.e_rdata = erd; x.e_we = ewe; x.e_ill = eill;
        x.e_vvalid = evv; x.e_vinstr = evi; x.e_kind = ek; x.e_vvl = evl; x.e_vsew = evs;
        x.e_vl = el; x.e_vtype = etp;
        return x;
    endfunction

    task automatic applyStimulus(input int valid, input logic [31:0] instr, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input int rr, input int vr, input int fl);
        issue_valid_i  = (valid != 0);
        issue_instr_i  = instr;
        issue_rs1_i    = rs1;
        issue_rs2_i    = rs2;
        resp_ready_i   = (rr != 0);
        vinstr_ready_i = (vr != 0);
        flush_i        = (fl != 0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        // name, valid, instr, rs1, rs2, rr, vr, flush |
        // ready, rvalid, rdata, we, ill, vvalid, vinstr, kind, vvl, vsew, vl, vtype
        vecs.push_back(mk("vsetvli_e32m2", 1, vsetvli(5, 6, 'h011), 100, 0, 1, 1, 0,
                          1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 8, 'h11));
        vecs.push_back(mk("vsetivli_e8m1", 1, vsetivli(0, 3, 0), 0, 0, 1, 1, 0,
                          1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk("opv_snapshot", 1, opv(4), 'hAAAA, 'hBBBB, 1, 0, 0,
                          1, 1, 0, 0, 0, 1, opv(4), 2, 3, 0, 3, 0));
        vecs.push_back(mk("idle_pop", 0, 0, 0, 0, 1, 1, 0,
                          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk("bp_load1", 1, ld(1), 0, 0, 1, 0, 0,
                          1, 1, 0, 0, 0, 1, ld(1), 0, 3, 0, 3, 0));
        vecs.push_back(mk("bp_store2", 1, st(2), 0, 0, 1, 0, 0,
                          1, 1, 0, 0, 0, 1, ld(1), 0, 3, 0, 3, 0));
        vecs.push_back(mk("bp_opv3", 1, opv(3), 0, 0, 1, 0, 0,
                          1, 1, 0, 0, 0, 1, ld(1), 0, 3, 0, 3, 0));
        vecs.push_back(mk("bp_load4", 1, ld(4), 0, 0, 1, 0, 0,
                          1, 1, 0, 0, 0, 1, ld(1), 0, 3, 0, 3, 0));
        vecs.push_back(mk("full_stall", 1, opv(5), 0, 0, 1, 0, 0,
                          0, 0, 0, 0, 0, 1, ld(1), 0, 3, 0, 3, 0));
        vecs.push_back(mk("full_pop_same_cycle", 1, opv(5), 0, 0, 1, 1, 0,
                          0, 0, 0, 0, 0, 1, st(2), 1, 3, 0, 3, 0));
        vecs.push_back(mk("refill", 1, opv(6), 0, 0, 1, 0, 0,
                          1, 1, 0, 0, 0, 1, st(2), 1, 3, 0, 3, 0));
        vecs.push_back(mk("drain1", 0, 0, 0, 0, 1, 1, 0,
                          0, 0, 0, 0, 0, 1, opv(3), 2, 3, 0, 3, 0));
        vecs.push_back(mk("drain2", 0, 0, 0, 0, 1, 1, 0,
                          1, 0, 0, 0, 0, 1, ld(4), 0, 3, 0, 3, 0));
        vecs.push_back(mk("drain3", 0, 0, 0, 0, 1, 1, 0,
                          1, 0, 0, 0, 0, 1, opv(6), 2, 3, 0, 3, 0));
        vecs.push_back(mk("drain4", 0, 0, 0, 0, 1, 1, 0,
                          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        vecs.push_back(mk("vsetvli_avlmax", 1, vsetvli(7, 0, 'h011), 'h1234, 0, 1, 0, 0,
                          1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 8, 'h11));
        vecs.push_back(mk("ld_after_cfg", 1, ld(8), 0, 0, 1, 0, 0,
                          1, 1, 0, 0, 0, 1, ld(8), 0, 8, 2, 8, 'h11));
        vecs.push_back(mk("vsetvli_keepvl", 1, vsetvli(0, 0, 'h010), 'h1234, 0, 1, 1, 0,
                          1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 4, 'h10));
        vecs.push_back(mk("vsetvl_vill_sew", 1, vsetvl(9, 10, 11), 5, 'h18, 1, 1, 0,
                          1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 'h8000_0000));
        vecs.push_back(mk("ld_under_vill", 1, ld(11), 0, 0, 1, 1, 0,
                          1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 'h8000_0000));
        vecs.push_back(mk("bad_opcode", 1, 'h00B5_0533, 0, 0, 1, 1, 0,
                          1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 'h8000_0000));
        vecs.push_back(mk("vsetivli_e16m8", 1, vsetivli(1, 31, 'h00B), 0, 0, 1, 1, 0,
                          1, 1, 31, 1, 0, 0, 0, 0, 0, 0, 31, 'hB));
        vecs.push_back(mk("bad_cfg_enc", 1, {7'b1000001, 5'd0, 5'd0, 3'b111, 5'd1, 7'h57}, 0, 0, 1, 1, 0,
                          1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 31, 'hB));
        vecs.push_back(mk("vsetvl_tama", 1, vsetvl(2, 3, 4), 1000, 'hC0, 1, 1, 0,
                          1, 1, 16, 1, 0, 0, 0, 0, 0, 0, 16, 'hC0));
        vecs.push_back(mk("vsetvl_vill_bit8", 1, vsetvl(0, 3, 4), 1000, 'h100, 1, 1, 0,
                          1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h8000_0000));
        vecs.push_back(mk("vsetvli_restore", 1, vsetvli(1, 1, 0), 5, 0, 1, 1, 0,
                          1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 5, 0));

        // Reset held for three cycles
        rst_ni = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk_i);
        checkOutput("reset.ready",  32'(issue_ready_o),  1);
        checkOutput("reset.rvalid", 32'(resp_valid_o),   0);
        checkOutput("reset.rdata",  resp_rdata_o,        0);
        checkOutput("reset.vvalid", 32'(vinstr_valid_o), 0);
        checkOutput("reset.vinstr", vinstr_o,            0);
        checkOutput("reset.vl",     vl_o,                0);
        checkOutput("reset.vtype",  vtype_o,             32'h8000_0000);
        rst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].instr, vecs[i].rs1, vecs[i].rs2,
                          vecs[i].rr, vecs[i].vr, vecs[i].fl);
            #1;
            checkOutput({vecs[i].name, ".ready"}, 32'(issue_ready_o), vecs[i].e_ready);
            @(posedge clk_i);
            @(negedge clk_i);
            checkOutput({vecs[i].name, ".rvalid"}, 32'(resp_valid_o),   vecs[i].e_rvalid);
            checkOutput({vecs[i].name, ".rdata"},  resp_rdata_o,        vecs[i].e_rdata);
            checkOutput({vecs[i].name, ".we"},     32'(resp_we_o),      vecs[i].e_we);
            checkOutput({vecs[i].name, ".ill"},    32'(resp_illegal_o), vecs[i].e_ill);
            checkOutput({vecs[i].name, ".vvalid"}, 32'(vinstr_valid_o), vecs[i].e_vvalid);
            checkOutput({vecs[i].name, ".vinstr"}, vinstr_o,            vecs[i].e_vinstr);
            checkOutput({vecs[i].name, ".kind"},   32'(vinstr_kind_o),  vecs[i].e_kind);
            checkOutput({vecs[i].name, ".vvl"},    vinstr_vl_o,         vecs[i].e_vvl);
            checkOutput({vecs[i].name, ".vsew"},   32'(vinstr_vsew_o),  vecs[i].e_vsew);
            checkOutput({vecs[i].name, ".vl"},     vl_o,                vecs[i].e_vl);
            checkOutput({vecs[i].name, ".vtype"},  vtype_o,             vecs[i].e_vtype);
        end

        // Flush with three entries queued and a response pending
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, opv(7 + i), 32'h100 + 32'(i), 0, 1, 0, 0);
            @(posedge clk_i);
            @(negedge clk_i);
        end
        checkOutput("pre_flush.vvalid", 32'(vinstr_valid_o), 1);
        checkOutput("pre_flush.rs1",    vinstr_rs1_o,        32'h100);
        checkOutput("pre_flush.rvalid", 32'(resp_valid_o),   1);
        applyStimulus(1, opv(10), 0, 0, 0, 0, 1);
        #1;
        checkOutput("flush.ready", 32'(issue_ready_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("flush.vvalid", 32'(vinstr_valid_o), 0);
        checkOutput("flush.rvalid", 32'(resp_valid_o),   0);
        checkOutput("flush.vl",     vl_o,                5);
        checkOutput("flush.vtype",  vtype_o,             0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("post_flush.ready", 32'(issue_ready_o), 1);
        @(negedge clk_i);

        // Asynchronous reset with the FIFO full
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, opv(11 + i), 0, 0, 1, 0, 0);
            @(posedge clk_i);
            @(negedge clk_i);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        #1;
        checkOutput("full.ready",  32'(issue_ready_o),  0);
        checkOutput("full.vvalid", 32'(vinstr_valid_o), 1);
        #1;
        rst_ni = 1'b0;
        #1;
        checkOutput("areset.ready",  32'(issue_ready_o),  1);
        checkOutput("areset.rvalid", 32'(resp_valid_o),   0);
        checkOutput("areset.vvalid", 32'(vinstr_valid_o), 0);
        checkOutput("areset.vinstr", vinstr_o,            0);
        checkOutput("areset.vl",     vl_o,                0);
        checkOutput("areset.vtype",  vtype_o,             32'h8000_0000);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // After reset vtype has vill, so a vector op must be rejected
        applyStimulus(1, opv(15), 0, 0, 1, 1, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("post_reset.ill",    32'(resp_illegal_o), 1);
        checkOutput("post_reset.vvalid", 32'(vinstr_valid_o), 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        @(negedge clk_i);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
